mem_ls_unit: RTL and testbench

//  Load/store front end between the CPU datapath and the dual-port RAM (port A side).

---
 rtl/mem_pkg.sv | 21 ++
 rtl/mem_io_regs.sv | 60 ++++++
 rtl/mem_ls_unit.sv | 145 ++++++++++++++
 tb/tb_mem_ls_unit.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the load/store front end: defaults, I/O map and FSM states.
package mem_pkg;

  localparam int MEM_DATA_WIDTH = 16;
  localparam int MEM_ADDR_WIDTH = 10;
  localparam logic [MEM_ADDR_WIDTH-1:0] MEM_IO_BASE = 10'h3F0;

  // The I/O window spans 16 words starting at the I/O base address
  localparam int IO_WINDOW = 16;
  localparam logic [3:0] KEY_OFS = 4'd0;
  localparam logic [3:0] LED_OFS = 4'd1;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ADDR,
    RD_DATA,
    IO
  } mem_state_e;

endpackage

// File: rtl/mem_io_regs.sv
// Memory-mapped I/O registers: keyboard code/flag capture, LED register, read mux.
module mem_io_regs
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = MEM_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            key_code,
  input  logic                  key_strobe,
  input  logic                  io_en,
  input  logic                  io_we,
  input  logic [3:0]            io_ofs,
  input  logic [DATA_WIDTH-1:0] io_wdata,
  output logic [DATA_WIDTH-1:0] io_rdata,
  output logic [DATA_WIDTH-1:0] led_out
);

  logic [7:0] key_reg;
  logic       key_flag;
  logic       key_clr;

  assign key_clr = io_en & ~io_we & (io_ofs == KEY_OFS);

  // Capture a new scan code on every strobe; a strobe wins over a clearing read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_reg  <= '0;
      key_flag <= 1'b0;
    end else if (key_strobe) begin
      key_reg  <= key_code;
      key_flag <= 1'b1;
    end else if (key_clr) begin
      key_flag <= 1'b0;
    end
  end

  // LED register written by stores to its offset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_out <= '0;
    end else if (io_en && io_we && (io_ofs == LED_OFS)) begin
      led_out <= io_wdata;
    end
  end

  // Read mux; returns the pre-edge register values so a colliding strobe is not visible
  always_comb begin
    io_rdata = '0;
    case (io_ofs)
      KEY_OFS: begin
        io_rdata[DATA_WIDTH-1] = key_flag;
        io_rdata[7:0]          = key_reg;
      end
      LED_OFS: io_rdata = led_out;
      default: io_rdata = '0;
    endcase
  end

endmodule

// File: rtl/mem_ls_unit.sv
// Load/store front end between the CPU datapath and RAM port A, with an I/O window.
module mem_ls_unit
  import mem_pkg::*;
#(
  parameter int                    DATA_WIDTH = MEM_DATA_WIDTH,
  parameter int                    ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] IO_BASE    = ADDR_WIDTH'(MEM_IO_BASE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_q,
  input  logic [7:0]            key_code,
  input  logic                  key_strobe,
  output logic [DATA_WIDTH-1:0] led_out
);

  mem_state_e state, state_nxt;

  logic                  accept;
  logic                  req_is_io;
  logic                  we_q;
  logic [ADDR_WIDTH:0]   addr_ext;
  logic [ADDR_WIDTH:0]   io_lo;
  logic [ADDR_WIDTH:0]   io_hi;
  logic                  io_en;
  logic [3:0]            io_ofs;
  logic [DATA_WIDTH-1:0] io_rdata;
  logic                  rsp_fire;
  logic [DATA_WIDTH-1:0] rsp_data_nxt;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid & req_ready;

  // One extra bit so the window end can lie past the top of the address space
  assign addr_ext  = {1'b0, req_addr};
  assign io_lo     = {1'b0, IO_BASE};
  assign io_hi     = io_lo + (ADDR_WIDTH+1)'(IO_WINDOW);
  assign req_is_io = (addr_ext >= io_lo) && (addr_ext < io_hi);

  // Window offset only needs the low 4 bits of (addr - base), so subtract just those
  assign io_ofs    = ram_addr[3:0] - IO_BASE[3:0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_is_io)   state_nxt = IO;
          else if (req_we) state_nxt = WR;
          else             state_nxt = RD_ADDR;
        end
      end
      WR:      state_nxt = IDLE;
      RD_ADDR: state_nxt = RD_DATA;
      RD_DATA: state_nxt = IDLE;
      IO:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Per-state control: I/O execute strobe and the response produced at this edge
  always_comb begin
    io_en        = 1'b0;
    rsp_fire     = 1'b0;
    rsp_data_nxt = '0;
    case (state)
      WR: begin
        rsp_fire = 1'b1;
      end
      RD_DATA: begin
        rsp_fire     = 1'b1;
        rsp_data_nxt = ram_q;
      end
      IO: begin
        io_en    = 1'b1;
        rsp_fire = 1'b1;
        if (!we_q) rsp_data_nxt = io_rdata;
      end
      default: begin
        io_en        = 1'b0;
        rsp_fire     = 1'b0;
        rsp_data_nxt = '0;
      end
    endcase
  end

  // Registered RAM interface and response; ram_addr/ram_data double as the request latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_addr  <= '0;
      ram_data  <= '0;
      ram_we    <= 1'b0;
      we_q      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      if (accept) begin
        ram_addr <= req_addr;
        ram_data <= req_wdata;
        we_q     <= req_we;
        ram_we   <= req_we & ~req_is_io;
      end else if (state == WR) begin
        ram_we <= 1'b0;
      end
      rsp_valid <= rsp_fire;
      if (rsp_fire) rsp_rdata <= rsp_data_nxt;
    end
  end

  mem_io_regs #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_io_regs (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_code  (key_code),
    .key_strobe(key_strobe),
    .io_en     (io_en),
    .io_we     (we_q),
    .io_ofs    (io_ofs),
    .io_wdata  (ram_data),
    .io_rdata  (io_rdata),
    .led_out   (led_out)
  );

endmodule

// File: tb/tb_mem_ls_unit.sv
// Scoreboard bench for mem_ls_unit with a behavioural synchronous RAM on port A.
module tb_mem_ls_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [9:0]  req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic [9:0]  ram_addr;
  logic [15:0] ram_data;
  logic        ram_we;
  logic [15:0] ram_q;
  logic [7:0]  key_code = '0;
  logic        key_strobe = 1'b0;
  logic [15:0] led_out;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   last_acc = 0;

  logic [15:0] mem [0:1023];

  mem_ls_unit #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(10),
    .IO_BASE   (10'h3F0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data),
    .ram_we    (ram_we),
    .ram_q     (ram_q),
    .key_code  (key_code),
    .key_strobe(key_strobe),
    .led_out   (led_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM, one cycle read latency
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data;
    ram_q <= mem[ram_addr];
  end

  // Pops one expectation per response; also flags any RAM write into the I/O window
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (ram_we === 1'b1) begin
          n_cmp++;
          if (ram_addr >= 10'h3F0) begin
            n_bad++;
            $display("FAIL io_ram_we: ram_we=1 at ram_addr=%h, required ram_we=0 in I/O window", ram_addr);
          end
        end
        if (rsp_valid === 1'b1) begin
          n_cmp++;
          if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_rsp: rsp_valid=1 rdata=%h at cycle %0d, required no response", rsp_rdata, cyc);
          end else begin
            e = sb.pop_front();
            if (rsp_rdata !== e.data) begin
              n_bad++;
              $display("FAIL rsp_rdata: got %h, required %h", rsp_rdata, e.data);
            end
            n_cmp++;
            if (cyc != e.cyc) begin
              n_bad++;
              $display("FAIL rsp_timing: response at cycle %0d, required %0d", cyc, e.cyc);
            end
          end
        end
      end
    end
  endtask

  // Present one request; returns 1 time unit after the accepting edge. lat<=0: no response expected.
  task automatic issue(input logic we, input logic [9:0] a, input logic [15:0] d,
                       input logic [15:0] exp_d, input int lat);
    int w;
    w = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL accept_timeout: req_ready=%b, required 1", req_ready);
    end else begin
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
      @(posedge clk);
      #1;
      last_acc = cyc;
      if (lat > 0) sb.push_back('{exp_d, cyc + lat});
      req_valid = 1'b0;
      req_we    = 1'b0;
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 40) begin
      @(negedge clk);
      w++;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic strobe_key(input logic [7:0] code);
    @(negedge clk);
    key_code   = code;
    key_strobe = 1'b1;
    @(negedge clk);
    key_strobe = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_cmp += 7;
    if (req_ready !== 1'b1)  begin n_bad++; $display("FAIL reset_ready: got %b, required 1", req_ready); end
    if (rsp_valid !== 1'b0)  begin n_bad++; $display("FAIL reset_rsp_valid: got %b, required 0", rsp_valid); end
    if (rsp_rdata !== 16'h0) begin n_bad++; $display("FAIL reset_rsp_rdata: got %h, required 0000", rsp_rdata); end
    if (ram_addr !== 10'h0)  begin n_bad++; $display("FAIL reset_ram_addr: got %h, required 000", ram_addr); end
    if (ram_data !== 16'h0)  begin n_bad++; $display("FAIL reset_ram_data: got %h, required 0000", ram_data); end
    if (ram_we !== 1'b0)     begin n_bad++; $display("FAIL reset_ram_we: got %b, required 0", ram_we); end
    if (led_out !== 16'h0)   begin n_bad++; $display("FAIL reset_led_out: got %h, required 0000", led_out); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_store_load();
    issue(1'b1, 10'h005, 16'hBEEF, 16'h0000, 1);
    issue(1'b0, 10'h005, 16'h0000, 16'hBEEF, 2);
    drain();
    n_cmp++;
    if (rsp_rdata !== 16'hBEEF) begin
      n_bad++;
      $display("FAIL rdata_hold: got %h, required BEEF", rsp_rdata);
    end
  endtask

  task automatic test_back_to_back();
    int a1, a2, a3;
    issue(1'b1, 10'h001, 16'h1111, 16'h0000, 1);
    a1 = last_acc;
    issue(1'b1, 10'h002, 16'h2222, 16'h0000, 1);
    a2 = last_acc;
    issue(1'b0, 10'h001, 16'h0000, 16'h1111, 2);
    a3 = last_acc;
    issue(1'b0, 10'h002, 16'h0000, 16'h2222, 2);
    drain();
    n_cmp += 2;
    if (a2 - a1 != 2) begin n_bad++; $display("FAIL b2b_store_gap: %0d cycles, required 2", a2 - a1); end
    if (a3 - a2 != 2) begin n_bad++; $display("FAIL b2b_load_gap: %0d cycles, required 2", a3 - a2); end
    // Last RAM word below the I/O window
    issue(1'b1, 10'h3EF, 16'h1234, 16'h0000, 1);
    issue(1'b0, 10'h3EF, 16'h0000, 16'h1234, 2);
    drain();
  endtask

  task automatic test_key();
    strobe_key(8'h1C);
    issue(1'b0, 10'h3F0, 16'h0000, 16'h801C, 1);
    issue(1'b0, 10'h3F0, 16'h0000, 16'h001C, 1);
    drain();
  endtask

  task automatic test_led();
    issue(1'b1, 10'h3F1, 16'h00FF, 16'h0000, 1);
    @(posedge clk);
    #1;
    n_cmp++;
    if (led_out !== 16'h00FF) begin n_bad++; $display("FAIL led_write: got %h, required 00FF", led_out); end
    issue(1'b0, 10'h3F1, 16'h0000, 16'h00FF, 1);
    issue(1'b1, 10'h3F5, 16'hABCD, 16'h0000, 1);
    issue(1'b0, 10'h3F5, 16'h0000, 16'h0000, 1);
    issue(1'b0, 10'h3FF, 16'h0000, 16'h0000, 1);
    drain();
    n_cmp++;
    if (led_out !== 16'h00FF) begin n_bad++; $display("FAIL led_hold: got %h, required 00FF", led_out); end
  endtask

  task automatic test_strobe_collision();
    strobe_key(8'h11);
    issue(1'b0, 10'h3F0, 16'h0000, 16'h8011, 1);
    key_code   = 8'h2A;
    key_strobe = 1'b1;
    @(posedge clk);
    #1;
    key_strobe = 1'b0;
    issue(1'b0, 10'h3F0, 16'h0000, 16'h802A, 1);
    issue(1'b0, 10'h3F0, 16'h0000, 16'h002A, 1);
    drain();
  endtask

  task automatic test_reset_mid();
    issue(1'b0, 10'h005, 16'h0000, 16'h0000, 0);
    rst_n = 1'b0;
    #1;
    n_cmp += 3;
    if (ram_we !== 1'b0)    begin n_bad++; $display("FAIL rd_abort_ram_we: got %b, required 0", ram_we); end
    if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rd_abort_rsp: got %b, required 0", rsp_valid); end
    if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rd_abort_ready: got %b, required 1", req_ready); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp += 2;
    if (req_ready !== 1'b1)  begin n_bad++; $display("FAIL post_reset_ready: got %b, required 1", req_ready); end
    if (led_out !== 16'h0)   begin n_bad++; $display("FAIL post_reset_led: got %h, required 0000", led_out); end
    repeat (4) @(negedge clk);
    issue(1'b1, 10'h007, 16'h5555, 16'h0000, 0);
    n_cmp++;
    if (ram_we !== 1'b1) begin n_bad++; $display("FAIL wr_ram_we: got %b, required 1", ram_we); end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (ram_we !== 1'b0) begin n_bad++; $display("FAIL wr_abort_ram_we: got %b, required 0", ram_we); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    // Key register was cleared by reset
    issue(1'b0, 10'h3F0, 16'h0000, 16'h0000, 1);
    drain();
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_store_load();
    test_back_to_back();
    test_key();
    test_led();
    test_strobe_collision();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
